// File: rtl/sig_capture_pkg.sv
// sig_capture_pkg: shared state encoding and defaults for the capture sink
package sig_capture_pkg;
  localparam int N_BITS_DEF = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port RAM, one write port and a registered read-first read port
module capture_ram
  import sig_capture_pkg::*;
#(
  parameter int width     = 2 * N_BITS_DEF,
  parameter int depth     = 1024,
  parameter int addr_bits = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [addr_bits-1:0] i_waddr,
  input  logic [width-1:0]     i_wdata,
  input  logic                 i_re,
  input  logic [addr_bits-1:0] i_raddr,
  output logic [width-1:0]     o_rdata
);
  logic [width-1:0] r_mem [depth];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // separate process so a same-address write this edge is not visible to the read
  always_ff @(posedge clk or posedge rst)
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/sig_capture.sv
// sig_capture: armed stream sink storing depth cos/sin pairs, counting rising cosine zero crossings
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int n_bits    = N_BITS_DEF,
  parameter int depth     = 1024,
  parameter int addr_bits = $clog2(depth)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     s_axis_data_tvalid,
  input  logic signed [n_bits-1:0] cosine,
  input  logic signed [n_bits-1:0] sine,
  output logic                     m_axis_data_tready,
  output logic                     done,
  output logic [addr_bits:0]       samples_captured,
  output logic [addr_bits:0]       zc_count,
  input  logic                     rd_en,
  input  logic [addr_bits-1:0]     rd_addr,
  output logic                     rd_valid,
  output logic signed [n_bits-1:0] rd_cosine,
  output logic signed [n_bits-1:0] rd_sine
);
  state_t r_state, w_state_nxt;
  logic w_acc, w_start, w_last, w_rise, r_first;
  logic signed [n_bits-1:0] r_prev_cos;
  logic [addr_bits:0] r_cnt, r_zc;
  logic [2*n_bits-1:0] w_rdata;
  always_comb begin
    m_axis_data_tready = r_state == CAPTURE;
    done = r_state == DONE;
    w_acc = s_axis_data_tvalid & m_axis_data_tready;
    w_start = arm & ~m_axis_data_tready;
    w_last = r_cnt == (addr_bits + 1)'(depth - 1);
    w_rise = ~r_first & r_prev_cos[n_bits-1] & ~cosine[n_bits-1];
    w_state_nxt = w_start ? CAPTURE : (w_acc && w_last) ? DONE : r_state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // the first sample after arm only seeds prev_cos, it cannot be a crossing
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_zc <= '0;
      r_first <= 1'b1;
      r_prev_cos <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_zc <= '0;
      r_first <= 1'b1;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      r_zc <= r_zc + {{addr_bits{1'b0}}, w_rise};
      r_first <= 1'b0;
      r_prev_cos <= cosine;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) rd_valid <= 1'b0;
    else rd_valid <= rd_en;
  capture_ram #(
    .width    (2 * n_bits),
    .depth    (depth),
    .addr_bits(addr_bits)
  ) u_ram (
    .clk    (clk),
    .rst    (reset),
    .i_we   (w_acc),
    .i_waddr(r_cnt[addr_bits-1:0]),
    .i_wdata({cosine, sine}),
    .i_re   (rd_en),
    .i_raddr(rd_addr),
    .o_rdata(w_rdata)
  );
  assign samples_captured = r_cnt;
  assign zc_count = r_zc;
  assign {rd_cosine, rd_sine} = w_rdata;
endmodule
